// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and data paths.
// Round-robin on conflict, registered bus request, response to the granted master only.
module mem_arbiter #(
  parameter int XLEN = 32,
  parameter int STRB = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_flush,
  output logic            i_ready,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [STRB-1:0] d_wstrb,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_valid,
  output logic            mem_instr,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [STRB-1:0] mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DRAIN_I
  } state_t;

  state_t state;
  // 1 = data path was granted last, 0 = fetch path
  logic   last;

  logic ireq;
  logic dreq;
  logic pick_d;

  // a flushed fetch is not eligible; on conflict the non-last master wins
  always_comb begin
    ireq   = i_valid & ~i_flush;
    dreq   = d_valid;
    pick_d = dreq & (~ireq | ~last);
  end

  // responses go only to the master owning the bus; data gated to zero otherwise
  always_comb begin
    i_ready = (state == BUSY_I) & mem_ready & ~i_flush;
    d_ready = (state == BUSY_D) & mem_ready;
    i_rdata = i_ready ? mem_rdata : '0;
    d_rdata = d_ready ? mem_rdata : '0;
  end

  // arbitration FSM with registered bus request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state     <= BUSY_D;
            last      <= 1'b1;
            mem_valid <= 1'b1;
            mem_instr <= 1'b0;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
          end else if (ireq) begin
            state     <= BUSY_I;
            last      <= 1'b0;
            mem_valid <= 1'b1;
            mem_instr <= 1'b1;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
          end else if (i_flush) begin
            state <= DRAIN_I;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
          end
        end
        DRAIN_I: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Memory model answers with addr ^ K after a programmable wait.
module tb_mem_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct packed {
    logic        instr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int   total;
  int   bad;
  int   lat;
  int   wcnt;
  int   icnt;
  int   dcnt;
  int   ib;
  int   db;
  exp_t q[$];

  mem_arbiter #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .i_addr(i_addr),
    .i_flush(i_flush),
    .i_ready(i_ready),
    .i_rdata(i_rdata),
    .d_valid(d_valid),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_wstrb(d_wstrb),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_ready = mem_valid && (wcnt >= lat);
  assign mem_rdata = mem_addr ^ K;

  // wait-state counter of the memory model
  always @(posedge clk) begin
    if (!mem_valid || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // pop the scoreboard on every response
  always @(negedge clk) begin
    if (rst && (i_ready || d_ready)) begin
      exp_t e;
      check("excl", 32'(i_ready & d_ready), 0);
      if (i_ready) icnt++;
      if (d_ready) dcnt++;
      if (q.size() == 0) begin
        check("sb_extra", q.size(), 1);
      end else begin
        e = q.pop_front();
        check("sb_who", 32'(i_ready), 32'(e.instr));
        check("sb_data", i_ready ? i_rdata : d_rdata, e.data);
      end
    end
  end

  task automatic push(input logic instr, input logic [31:0] a);
    exp_t e;
    e.instr = instr;
    e.data  = a ^ K;
    q.push_back(e);
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick3();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    i_valid = 1'b0;
    i_addr  = '0;
    i_flush = 1'b0;
    d_valid = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
    lat     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ib  = icnt;
    db  = dcnt;
  endtask

  task automatic wrap(input string tag, input int ni, input int nd);
    repeat (3) tick1();
    check({tag, "_icnt"}, icnt - ib, ni);
    check({tag, "_dcnt"}, dcnt - db, nd);
    check({tag, "_left"}, q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    icnt  = 0;
    dcnt  = 0;
    wcnt  = 0;
    rst   = 1'b0;
    lat   = 0;
    #2;
    check("rst_mvalid", 32'(mem_valid), 0);
    check("rst_minstr", 32'(mem_instr), 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwdata", mem_wdata, 0);
    check("rst_mwstrb", 32'(mem_wstrb), 0);
    check("rst_iready", 32'(i_ready), 0);
    check("rst_dready", 32'(d_ready), 0);

    // back-to-back fetches, zero wait
    do_reset();
    i_valid = 1'b1;
    i_addr  = 32'h100;
    for (int k = 0; k < 5; k++) push(1'b1, 32'h100);
    tick3();
    check("t1_valid", 32'(mem_valid), 1);
    check("t1_instr", 32'(mem_instr), 1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_iready", 32'(i_ready), 1);
    check("t1_rdata", i_rdata, 32'h100 ^ K);
    tick3();
    check("t1_gap_rdy", 32'(i_ready), 0);
    check("t1_gap_vld", 32'(mem_valid), 0);
    repeat (8) @(posedge clk);
    #1;
    i_valid = 1'b0;
    wrap("t1", 5, 0);

    // continuous conflict: D, I, D, I, ...
    do_reset();
    i_valid = 1'b1;
    i_addr  = 32'h100;
    d_valid = 1'b1;
    d_addr  = 32'h2000;
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 32'h2000);
      push(1'b1, 32'h100);
    end
    for (int k = 1; k <= 12; k++) begin
      tick3();
      check("t2_busy", 32'(mem_valid), 32'(k % 2));
      if (k % 2 == 1)
        check("t2_instr", 32'(mem_instr), 32'(k % 4 == 3));
    end
    i_valid = 1'b0;
    d_valid = 1'b0;
    wrap("t2", 3, 3);

    // store with 3 wait states
    do_reset();
    lat     = 3;
    d_valid = 1'b1;
    d_addr  = 32'h2040;
    d_wdata = 32'hDEADBEEF;
    d_wstrb = 4'hF;
    push(1'b0, 32'h2040);
    for (int k = 0; k < 4; k++) begin
      tick3();
      check("t3_valid", 32'(mem_valid), 1);
      check("t3_addr", mem_addr, 32'h2040);
      check("t3_wdata", mem_wdata, 32'hDEADBEEF);
      check("t3_wstrb", 32'(mem_wstrb), 32'hF);
      check("t3_instr", 32'(mem_instr), 0);
      check("t3_dready", 32'(d_ready), 32'(k == 3));
    end
    tick1();
    d_valid = 1'b0;
    wrap("t3", 0, 1);

    // flush while waiting: drain, then pending data grant
    do_reset();
    lat     = 3;
    i_valid = 1'b1;
    i_addr  = 32'h300;
    tick1();
    i_flush = 1'b1;
    d_valid = 1'b1;
    d_addr  = 32'h400;
    push(1'b0, 32'h400);
    tick1();
    i_flush = 1'b0;
    i_valid = 1'b0;
    #2;
    check("t4_drain_vld", 32'(mem_valid), 1);
    check("t4_drain_ins", 32'(mem_instr), 1);
    check("t4_drain_adr", mem_addr, 32'h300);
    check("t4_drain_rdy", 32'(i_ready), 0);
    tick1();
    i_flush = 1'b1;
    #2;
    check("t4_reflush", 32'(mem_valid), 1);
    tick1();
    i_flush = 1'b0;
    #2;
    check("t4_mready", 32'(mem_ready), 1);
    check("t4_no_irdy", 32'(i_ready), 0);
    check("t4_no_drdy", 32'(d_ready), 0);
    tick1();
    lat = 0;
    #2;
    check("t4_idle", 32'(mem_valid), 0);
    tick1();
    #2;
    check("t4_d_instr", 32'(mem_instr), 0);
    check("t4_d_addr", mem_addr, 32'h400);
    check("t4_d_ready", 32'(d_ready), 1);
    tick1();
    d_valid = 1'b0;
    wrap("t4", 0, 1);

    // flush coincident with ready, then flush blocks grant in IDLE
    do_reset();
    i_valid = 1'b1;
    i_addr  = 32'h500;
    tick1();
    i_flush = 1'b1;
    #2;
    check("t5_vld", 32'(mem_valid), 1);
    check("t5_rdy", 32'(i_ready), 0);
    check("t5_rdata", i_rdata, 0);
    tick1();
    #2;
    check("t5_idle", 32'(mem_valid), 0);
    tick1();
    i_flush = 1'b0;
    push(1'b1, 32'h500);
    #2;
    check("t5_nogrant", 32'(mem_valid), 0);
    tick1();
    #2;
    check("t5_grant", 32'(mem_valid), 1);
    check("t5_irdy", 32'(i_ready), 1);
    tick1();
    i_valid = 1'b0;
    wrap("t5", 1, 0);

    // async reset mid BUSY_D, then first conflict goes to D
    do_reset();
    lat     = 5;
    d_valid = 1'b1;
    d_addr  = 32'h600;
    d_wdata = 32'h1234;
    d_wstrb = 4'h3;
    tick1();
    tick3();
    check("t6_busy", 32'(mem_valid), 1);
    check("t6_wstrb", 32'(mem_wstrb), 32'h3);
    #1;
    rst = 1'b0;
    #1;
    check("t6_r_vld", 32'(mem_valid), 0);
    check("t6_r_addr", mem_addr, 0);
    check("t6_r_wdata", mem_wdata, 0);
    check("t6_r_wstrb", 32'(mem_wstrb), 0);
    check("t6_r_drdy", 32'(d_ready), 0);
    check("t6_r_drdata", d_rdata, 0);
    tick1();
    d_valid = 1'b0;
    #3;
    rst = 1'b1;
    ib  = icnt;
    db  = dcnt;
    tick1();
    lat     = 0;
    d_valid = 1'b1;
    d_addr  = 32'h700;
    d_wstrb = 4'h0;
    i_valid = 1'b1;
    i_addr  = 32'h180;
    push(1'b0, 32'h700);
    push(1'b1, 32'h180);
    tick3();
    check("t6_first_d", 32'(mem_instr), 0);
    check("t6_drdy", 32'(d_ready), 1);
    tick3();
    check("t6_turn", 32'(mem_valid), 0);
    tick3();
    check("t6_then_i", 32'(mem_instr), 1);
    check("t6_irdy", 32'(i_ready), 1);
    i_valid = 1'b0;
    d_valid = 1'b0;
    wrap("t6", 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
